// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: req/gnt request phase plus rvalid response phase.
// The master side is the pipeline stage, the slave side is the data memory.
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a req/gnt/rvalid port, aligns/extends load data,
// stalls upstream while an access is outstanding and registers the write-back fields.
module mem_stage #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_wmem_en_i,
  input  logic              mem_rmem_en_i,
  input  logic [ADDR_W-1:0] mem_mem_addr_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic              mem_wreg_en_i,
  input  logic [4:0]        mem_wreg_addr_i,
  input  logic [31:0]       mem_wreg_data_i,
  mem_stage_if.master       dmem,
  output logic              hold_o,
  output logic              wb_wreg_en_o,
  output logic [4:0]        wb_wreg_addr_o,
  output logic [31:0]       wb_wreg_data_o,
  output logic              exc_misalign_o,
  output logic              exc_bus_err_o
);

  localparam int unsigned    CntW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitGnt,
    StWaitR
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            r_wb_en;
  logic [4:0]      r_wb_addr;
  logic [31:0]     r_wb_data;
  logic            r_exc_misalign;
  logic            r_exc_bus_err;

  logic [1:0]      w_off;
  logic            w_mem_op;
  logic            w_f3_ok;
  logic            w_illegal;
  logic            w_misalign;
  logic            w_access;
  logic [3:0]      w_be_st;
  logic [31:0]     w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load_val;
  logic            w_req;
  logic            w_timeout;
  logic            w_load_done;

  assign w_off    = mem_mem_addr_i[1:0];
  assign w_mem_op = mem_wmem_en_i | mem_rmem_en_i;

  // Unsigned sizes exist only for loads.
  always_comb begin
    w_f3_ok = 1'b0;
    case (mem_funct3_i)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = ~mem_wmem_en_i;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  assign w_illegal  = w_mem_op & ((mem_wmem_en_i & mem_rmem_en_i) | ~w_f3_ok);
  assign w_misalign = w_mem_op & ~w_illegal &
                      (((mem_funct3_i[1:0] == 2'b01) & w_off[0]) |
                       ((mem_funct3_i[1:0] == 2'b10) & (w_off != 2'b00)));
  assign w_access   = w_mem_op & ~w_illegal & ~w_misalign;

  always_comb begin
    w_be_st = 4'b1111;
    w_wdata = mem_wreg_data_i;
    case (mem_funct3_i[1:0])
      2'b00: begin
        w_be_st = 4'b0001 << w_off;
        w_wdata = {4{mem_wreg_data_i[7:0]}};
      end
      2'b01: begin
        w_be_st = 4'b0011 << w_off;
        w_wdata = {2{mem_wreg_data_i[15:0]}};
      end
      default: begin
        w_be_st = 4'b1111;
        w_wdata = mem_wreg_data_i;
      end
    endcase
  end

  assign dmem.req   = w_req;
  assign dmem.we    = mem_wmem_en_i;
  assign dmem.addr  = {mem_mem_addr_i[ADDR_W-1:2], 2'b00};
  assign dmem.be    = mem_wmem_en_i ? w_be_st : 4'b0000;
  assign dmem.wdata = w_wdata;

  assign w_byte = dmem.rdata[{w_off, 3'b000} +: 8];
  assign w_half = dmem.rdata[{w_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load_val = dmem.rdata;
    case (mem_funct3_i)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'h000000, w_byte};
      3'b101:  w_load_val = {16'h0000, w_half};
      default: w_load_val = dmem.rdata;
    endcase
  end

  // Inputs stay frozen while hold_o is high, so decode stays valid in the wait states.
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt + CntW'(1);
    w_req       = 1'b0;
    hold_o      = 1'b0;
    w_timeout   = 1'b0;
    w_load_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_req   = w_access;
        w_cnt_d = '0;
        if (w_access) begin
          if (!dmem.gnt) begin
            w_state_d = StWaitGnt;
            hold_o    = 1'b1;
          end else if (mem_rmem_en_i) begin
            w_state_d = StWaitR;
            hold_o    = 1'b1;
          end
        end
      end
      StWaitGnt: begin
        w_req = 1'b1;
        if (dmem.gnt) begin
          w_cnt_d = '0;
          if (mem_rmem_en_i) begin
            w_state_d = StWaitR;
            hold_o    = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end else if (r_cnt == CntLast) begin
          w_state_d = StIdle;
          w_timeout = 1'b1;
        end else begin
          hold_o = 1'b1;
        end
      end
      StWaitR: begin
        if (dmem.rvalid) begin
          w_state_d   = StIdle;
          w_load_done = 1'b1;
        end else if (r_cnt == CntLast) begin
          w_state_d = StIdle;
          w_timeout = 1'b1;
        end else begin
          hold_o = 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_wb_en        <= 1'b0;
      r_wb_addr      <= '0;
      r_wb_data      <= '0;
      r_exc_misalign <= 1'b0;
      r_exc_bus_err  <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_exc_misalign <= (r_state == StIdle) & w_misalign;
      r_exc_bus_err  <= ((r_state == StIdle) & w_illegal) | w_timeout;
      if (hold_o) begin
        r_wb_en <= 1'b0;
      end else begin
        r_wb_addr <= mem_wreg_addr_i;
        if (w_load_done) begin
          r_wb_en   <= mem_wreg_en_i;
          r_wb_data <= w_load_val;
        end else if (w_mem_op) begin
          // Completed store, dropped access or timeout: nothing to write back.
          r_wb_en   <= 1'b0;
          r_wb_data <= mem_wreg_data_i;
        end else begin
          r_wb_en   <= mem_wreg_en_i;
          r_wb_data <= mem_wreg_data_i;
        end
      end
    end
  end

  assign wb_wreg_en_o   = r_wb_en;
  assign wb_wreg_addr_o = r_wb_addr;
  assign wb_wreg_data_o = r_wb_data;
  assign exc_misalign_o = r_exc_misalign;
  assign exc_bus_err_o  = r_exc_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized accesses checked
// against a size/offset arithmetic model and a latency model of the handshake.
module tb_mem_stage;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_wmem_en = 1'b0;
  logic        mem_rmem_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [2:0]  mem_f3 = '0;
  logic        mem_wen = 1'b0;
  logic [4:0]  mem_wa = '0;
  logic [31:0] mem_wd = '0;
  logic        hold_o;
  logic        wb_wreg_en_o;
  logic [4:0]  wb_wreg_addr_o;
  logic [31:0] wb_wreg_data_o;
  logic        exc_misalign_o;
  logic        exc_bus_err_o;

  int n_checks = 0;
  int n_errors = 0;

  int          obs_req_cyc;
  int          obs_hold_cyc;
  int          obs_bubble;
  bit          obs_stable;
  bit          obs_expired;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic [31:0] obs_addr;
  logic        obs_we;

  mem_stage_if #(.ADDR_W(32)) dmem_if ();

  mem_stage #(.ADDR_W(32), .TIMEOUT_CYC(T)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_wmem_en_i   (mem_wmem_en),
    .mem_rmem_en_i   (mem_rmem_en),
    .mem_mem_addr_i  (mem_addr),
    .mem_funct3_i    (mem_f3),
    .mem_wreg_en_i   (mem_wen),
    .mem_wreg_addr_i (mem_wa),
    .mem_wreg_data_i (mem_wd),
    .dmem            (dmem_if),
    .hold_o          (hold_o),
    .wb_wreg_en_o    (wb_wreg_en_o),
    .wb_wreg_addr_o  (wb_wreg_addr_o),
    .wb_wreg_data_o  (wb_wreg_data_o),
    .exc_misalign_o  (exc_misalign_o),
    .exc_bus_err_o   (exc_bus_err_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int size_of(logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // 0 = non-memory, 1 = valid access, 2 = misaligned, 3 = bus error
  function automatic int op_kind(logic rd, logic wr, logic [2:0] f3, logic [31:0] a);
    int sz;
    if (!rd && !wr) return 0;
    if (rd && wr) return 3;
    sz = size_of(f3);
    if (sz == 0) return 3;
    if (wr && f3 > 3'd2) return 3;
    if ((a % 32'(sz)) != 0) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] exp_be(logic [2:0] f3, logic [31:0] a);
    int v;
    v = ((1 << size_of(f3)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(logic [2:0] f3, logic [31:0] d);
    if (size_of(f3) == 1) return (d % 256) * 32'h0101_0101;
    if (size_of(f3) == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    longint v;
    int unsigned off;
    off = a % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = longint'((w >> (8 * off)) % 256);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = longint'((w >> (16 * (off / 2))) % 65536);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_nop();
    mem_rmem_en = 1'b0;
    mem_wmem_en = 1'b0;
    mem_f3      = '0;
    mem_addr    = '0;
    mem_wen     = 1'b0;
    mem_wa      = '0;
    mem_wd      = '0;
  endtask

  // Presents one op and plays the memory: gnt offered at cycle g (never if g<0), rvalid r
  // cycles after the grant cycle+1 (never if r<0). Returns at posedge+1 after hold drops.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic wen,
                        input logic [4:0] wa, input int g, input int r,
                        input logic [31:0] rdat);
    int k;
    int gat;
    bit done;
    mem_rmem_en = rd;
    mem_wmem_en = wr;
    mem_f3      = f3;
    mem_addr    = a;
    mem_wd      = d;
    mem_wen     = wen;
    mem_wa      = wa;
    obs_req_cyc = 0;
    obs_hold_cyc = 0;
    obs_bubble  = 0;
    obs_stable  = 1'b1;
    obs_expired = 1'b0;
    obs_be      = '0;
    obs_wdata   = '0;
    obs_addr    = '0;
    obs_we      = 1'b0;
    k    = 0;
    gat  = -1;
    done = 1'b0;
    while (!done) begin
      if (k >= 20) begin
        obs_expired = 1'b1;
        break;
      end
      dmem_if.gnt = (gat < 0) && (k == g);
      if (gat < 0) begin
        dmem_if.rvalid = 1'($urandom_range(0, 1));
        dmem_if.rdata  = $urandom;
      end else begin
        dmem_if.rvalid = (r >= 0) && (k == gat + 1 + r);
        dmem_if.rdata  = dmem_if.rvalid ? rdat : $urandom;
      end
      #2;
      if (k > 0 && wb_wreg_en_o !== 1'b0) obs_bubble++;
      if (dmem_if.req === 1'b1) begin
        if (obs_req_cyc == 0) begin
          obs_be    = dmem_if.be;
          obs_wdata = dmem_if.wdata;
          obs_addr  = dmem_if.addr;
          obs_we    = dmem_if.we;
        end else if (obs_be !== dmem_if.be || obs_wdata !== dmem_if.wdata ||
                     obs_addr !== dmem_if.addr || obs_we !== dmem_if.we) begin
          obs_stable = 1'b0;
        end
        obs_req_cyc++;
        if (dmem_if.gnt) gat = k;
      end
      if (hold_o === 1'b1) obs_hold_cyc++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    drive_nop();
    dmem_if.gnt    = 1'b0;
    dmem_if.rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive_nop();
    repeat (3) @(posedge clk);
    #3;
    n_checks++; if (wb_wreg_en_o !== 1'b0) begin n_errors++;
      $display("FAIL reset_wb_en: got %b want 0", wb_wreg_en_o); end
    n_checks++; if (wb_wreg_addr_o !== 5'd0) begin n_errors++;
      $display("FAIL reset_wb_addr: got %h want 0", wb_wreg_addr_o); end
    n_checks++; if (wb_wreg_data_o !== 32'd0) begin n_errors++;
      $display("FAIL reset_wb_data: got %h want 0", wb_wreg_data_o); end
    n_checks++; if (exc_misalign_o !== 1'b0 || exc_bus_err_o !== 1'b0) begin n_errors++;
      $display("FAIL reset_exc: got %b%b want 00", exc_misalign_o, exc_bus_err_o); end
    n_checks++; if (hold_o !== 1'b0 || dmem_if.req !== 1'b0) begin n_errors++;
      $display("FAIL reset_hold_req: got %b%b want 00", hold_o, dmem_if.req); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lb();
    run_op(1'b1, 1'b0, 3'd0, 32'h1000_0003, 32'h0, 1'b1, 5'd5, 0, 0, 32'h80FF_FFFF);
    n_checks++; if (obs_be !== 4'b0000) begin n_errors++;
      $display("FAIL lb_be: got %b want 0000", obs_be); end
    n_checks++; if (obs_hold_cyc != 1) begin n_errors++;
      $display("FAIL lb_hold: got %0d want 1", obs_hold_cyc); end
    n_checks++; if (wb_wreg_en_o !== 1'b1 || wb_wreg_addr_o !== 5'd5) begin n_errors++;
      $display("FAIL lb_wb_en_addr: got %b/%0d want 1/5", wb_wreg_en_o, wb_wreg_addr_o); end
    n_checks++; if (wb_wreg_data_o !== 32'hFFFF_FF80) begin n_errors++;
      $display("FAIL lb_wb_data: got %h want ffffff80", wb_wreg_data_o); end
  endtask

  task automatic test_sh();
    run_op(1'b0, 1'b1, 3'd1, 32'h2000_0002, 32'h0000_1234, 1'b1, 5'd3, 3, -1, 32'h0);
    n_checks++; if (obs_be !== 4'b1100 || obs_wdata !== 32'h1234_1234) begin n_errors++;
      $display("FAIL sh_lanes: got %b/%h want 1100/12341234", obs_be, obs_wdata); end
    n_checks++; if (obs_req_cyc != 4 || !obs_stable) begin n_errors++;
      $display("FAIL sh_req: got %0d stable=%0b want 4 stable=1", obs_req_cyc, obs_stable); end
    n_checks++; if (obs_hold_cyc != 3) begin n_errors++;
      $display("FAIL sh_hold: got %0d want 3", obs_hold_cyc); end
    n_checks++; if (wb_wreg_en_o !== 1'b0) begin n_errors++;
      $display("FAIL sh_wb_en: got %b want 0", wb_wreg_en_o); end
  endtask

  task automatic test_misalign();
    run_op(1'b1, 1'b0, 3'd2, 32'h3000_0001, 32'h0, 1'b1, 5'd4, 0, 0, 32'h0);
    n_checks++; if (obs_req_cyc != 0 || obs_hold_cyc != 0) begin n_errors++;
      $display("FAIL mis_req_hold: got %0d/%0d want 0/0", obs_req_cyc, obs_hold_cyc); end
    n_checks++; if (exc_misalign_o !== 1'b1 || exc_bus_err_o !== 1'b0) begin n_errors++;
      $display("FAIL mis_exc: got %b%b want 10", exc_misalign_o, exc_bus_err_o); end
    n_checks++; if (wb_wreg_en_o !== 1'b0) begin n_errors++;
      $display("FAIL mis_wb_en: got %b want 0", wb_wreg_en_o); end
    @(posedge clk);
    #1;
    n_checks++; if (exc_misalign_o !== 1'b0) begin n_errors++;
      $display("FAIL mis_pulse: got %b want 0", exc_misalign_o); end
  endtask

  task automatic test_bus_err();
    logic [2:0] f3s [3] = '{3'd3, 3'd4, 3'd2};
    logic       rds [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_op(rds[i], 1'b1 ^ (i == 0), f3s[i], 32'h4000_0000, 32'h55, 1'b1, 5'd6, 0, 0, 32'h0);
      n_checks++; if (obs_req_cyc != 0 || obs_hold_cyc != 0) begin n_errors++;
        $display("FAIL berr_req_hold[%0d]: got %0d/%0d want 0/0", i, obs_req_cyc,
                 obs_hold_cyc); end
      n_checks++; if (exc_bus_err_o !== 1'b1 || exc_misalign_o !== 1'b0 ||
                      wb_wreg_en_o !== 1'b0) begin n_errors++;
        $display("FAIL berr_out[%0d]: got err=%b mis=%b wb=%b want 1/0/0", i, exc_bus_err_o,
                 exc_misalign_o, wb_wreg_en_o); end
    end
  endtask

  task automatic test_timeout();
    run_op(1'b1, 1'b0, 3'd5, 32'h5000_0002, 32'h0, 1'b1, 5'd7, -1, -1, 32'h0);
    n_checks++; if (obs_req_cyc != T + 1 || obs_hold_cyc != T) begin n_errors++;
      $display("FAIL to_gnt_cyc: got req=%0d hold=%0d want %0d/%0d", obs_req_cyc,
               obs_hold_cyc, T + 1, T); end
    n_checks++; if (exc_bus_err_o !== 1'b1 || wb_wreg_en_o !== 1'b0) begin n_errors++;
      $display("FAIL to_gnt_out: got err=%b wb=%b want 1/0", exc_bus_err_o, wb_wreg_en_o); end
    @(posedge clk);
    #1;
    n_checks++; if (exc_bus_err_o !== 1'b0) begin n_errors++;
      $display("FAIL to_pulse: got %b want 0", exc_bus_err_o); end
    run_op(1'b1, 1'b0, 3'd2, 32'h5000_0004, 32'h0, 1'b1, 5'd8, 1, -1, 32'h0);
    n_checks++; if (obs_hold_cyc != 1 + T || exc_bus_err_o !== 1'b1 ||
                    wb_wreg_en_o !== 1'b0) begin n_errors++;
      $display("FAIL to_rvalid: got hold=%0d err=%b wb=%b want %0d/1/0", obs_hold_cyc,
               exc_bus_err_o, wb_wreg_en_o, 1 + T); end
  endtask

  task automatic test_back_to_back();
    logic        pe;
    logic [4:0]  pa;
    logic [31:0] pd;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        n_checks++; if (wb_wreg_en_o !== pe || wb_wreg_addr_o !== pa ||
                        wb_wreg_data_o !== pd) begin n_errors++;
          $display("FAIL b2b_wb[%0d]: got %b/%0d/%h want %b/%0d/%h", i, wb_wreg_en_o,
                   wb_wreg_addr_o, wb_wreg_data_o, pe, pa, pd); end
      end
      if (i < 5) begin
        mem_rmem_en = 1'b0;
        mem_wmem_en = 1'b0;
        mem_f3      = 3'($urandom);
        mem_addr    = $urandom;
        mem_wen     = 1'($urandom);
        mem_wa      = 5'($urandom);
        mem_wd      = $urandom;
        pe = mem_wen;
        pa = mem_wa;
        pd = mem_wd;
        #2;
        n_checks++; if (hold_o !== 1'b0 || dmem_if.req !== 1'b0) begin n_errors++;
          $display("FAIL b2b_hold_req[%0d]: got %b%b want 00", i, hold_o, dmem_if.req); end
        @(posedge clk);
        #1;
      end
    end
    drive_nop();
  endtask

  task automatic test_reset_mid();
    mem_rmem_en = 1'b1;
    mem_f3      = 3'd2;
    mem_addr    = 32'h0000_0100;
    mem_wen     = 1'b1;
    mem_wa      = 5'd9;
    dmem_if.gnt = 1'b1;
    dmem_if.rvalid = 1'b0;
    @(posedge clk);
    #1;
    dmem_if.gnt = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_nop();
    dmem_if.rvalid = 1'b1;
    dmem_if.rdata  = 32'hDEAD_BEEF;
    #2;
    n_checks++; if (hold_o !== 1'b0 || dmem_if.req !== 1'b0 || wb_wreg_en_o !== 1'b0 ||
                    wb_wreg_addr_o !== 5'd0 || wb_wreg_data_o !== 32'd0 ||
                    exc_misalign_o !== 1'b0 || exc_bus_err_o !== 1'b0) begin n_errors++;
      $display("FAIL rstmid_outs: got hold=%b req=%b wb=%b/%0d/%h exc=%b%b want all 0",
               hold_o, dmem_if.req, wb_wreg_en_o, wb_wreg_addr_o, wb_wreg_data_o,
               exc_misalign_o, exc_bus_err_o); end
    @(posedge clk);
    #1;
    n_checks++; if (wb_wreg_en_o !== 1'b0 || wb_wreg_data_o !== 32'd0) begin n_errors++;
      $display("FAIL rstmid_rvalid: got %b/%h want 0/0", wb_wreg_en_o, wb_wreg_data_o); end
    dmem_if.rvalid = 1'b0;
    run_op(1'b0, 1'b1, 3'd2, 32'h0000_0200, 32'h1, 1'b0, 5'd0, 0, -1, 32'h0);
    n_checks++; if (obs_req_cyc != 1 || obs_hold_cyc != 0) begin n_errors++;
      $display("FAIL rstmid_idle: got req=%0d hold=%0d want 1/0", obs_req_cyc,
               obs_hold_cyc); end
  endtask

  task automatic test_random(input int n);
    logic        rd, wr, wen;
    logic [2:0]  f3;
    logic [31:0] a, d, rdat;
    logic [4:0]  wa;
    int          g, r, kind, exp_req, exp_hold;
    logic [2:0]  f3_list [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5: begin rd = 1'b0; wr = 1'b0; end
        6:                begin rd = 1'b1; wr = 1'b1; end
        7, 8, 9, 10, 11, 12: begin rd = 1'b1; wr = 1'b0; end
        default:          begin rd = 1'b0; wr = 1'b1; end
      endcase
      f3   = ($urandom_range(0, 9) == 0) ? 3'($urandom) : f3_list[$urandom_range(0, 4)];
      a    = $urandom;
      d    = $urandom;
      wen  = 1'($urandom);
      wa   = 5'($urandom);
      rdat = $urandom;
      g    = int'($urandom_range(0, T));
      r    = int'($urandom_range(0, T - 1));
      kind = op_kind(rd, wr, f3, a);
      run_op(rd, wr, f3, a, d, wen, wa, g, r, rdat);
      n_checks++; if (obs_expired) begin n_errors++;
        $display("FAIL rnd_bound[%0d]: hold never released", i); end
      if (kind == 1) begin
        exp_req  = g + 1;
        exp_hold = rd ? g + 1 + r : g;
        n_checks++; if (obs_req_cyc != exp_req || obs_hold_cyc != exp_hold || !obs_stable ||
                        obs_bubble != 0) begin n_errors++;
          $display("FAIL rnd_timing[%0d]: got req=%0d hold=%0d st=%0b bub=%0d want %0d/%0d/1/0",
                   i, obs_req_cyc, obs_hold_cyc, obs_stable, obs_bubble, exp_req,
                   exp_hold); end
        n_checks++; if (obs_addr !== (a & ~32'h3) || obs_we !== wr ||
                        obs_be !== (wr ? exp_be(f3, a) : 4'b0000)) begin n_errors++;
          $display("FAIL rnd_bus[%0d]: got %h/%b/%b want %h/%b/%b", i, obs_addr, obs_we,
                   obs_be, a & ~32'h3, wr, wr ? exp_be(f3, a) : 4'b0000); end
        if (wr) begin
          n_checks++; if (obs_wdata !== exp_wdata(f3, d) || wb_wreg_en_o !== 1'b0) begin
            n_errors++;
            $display("FAIL rnd_store[%0d]: got %h wb=%b want %h wb=0", i, obs_wdata,
                     wb_wreg_en_o, exp_wdata(f3, d)); end
        end else begin
          n_checks++; if (wb_wreg_en_o !== wen || wb_wreg_addr_o !== wa ||
                          wb_wreg_data_o !== exp_load(f3, a, rdat)) begin n_errors++;
            $display("FAIL rnd_load[%0d]: f3=%0d a=%h got %b/%0d/%h want %b/%0d/%h", i, f3,
                     a, wb_wreg_en_o, wb_wreg_addr_o, wb_wreg_data_o, wen, wa,
                     exp_load(f3, a, rdat)); end
        end
        n_checks++; if (exc_misalign_o !== 1'b0 || exc_bus_err_o !== 1'b0) begin n_errors++;
          $display("FAIL rnd_exc_ok[%0d]: got %b%b want 00", i, exc_misalign_o,
                   exc_bus_err_o); end
      end else if (kind == 0) begin
        n_checks++; if (obs_req_cyc != 0 || obs_hold_cyc != 0 || wb_wreg_en_o !== wen ||
                        wb_wreg_addr_o !== wa || wb_wreg_data_o !== d) begin n_errors++;
          $display("FAIL rnd_alu[%0d]: got req=%0d hold=%0d wb=%b/%0d/%h want 0/0/%b/%0d/%h",
                   i, obs_req_cyc, obs_hold_cyc, wb_wreg_en_o, wb_wreg_addr_o,
                   wb_wreg_data_o, wen, wa, d); end
      end else begin
        n_checks++; if (obs_req_cyc != 0 || obs_hold_cyc != 0 || wb_wreg_en_o !== 1'b0 ||
                        exc_misalign_o !== (kind == 2) ||
                        exc_bus_err_o !== (kind == 3)) begin n_errors++;
          $display("FAIL rnd_drop[%0d]: kind=%0d got req=%0d hold=%0d wb=%b exc=%b%b",
                   i, kind, obs_req_cyc, obs_hold_cyc, wb_wreg_en_o, exc_misalign_o,
                   exc_bus_err_o); end
      end
    end
  endtask

  initial begin
    dmem_if.gnt    = 1'b0;
    dmem_if.rvalid = 1'b0;
    dmem_if.rdata  = '0;
    test_reset();
    test_lb();
    test_sh();
    test_misalign();
    test_bus_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random(300);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
